rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised successor to the 4:1 combinational MUX.
- Selects one of N_CH WIDTH-bit channels and registers it onto an output with a valid/ready handshake.
- Two selection modes:
  - Manual: an external sel picks the channel.
  - Round-robin: a fair arbiter picks among requesting channels.
- Used as the front-end channel selector ahead of registered datapath stages in later labs.

Parameters:
- WIDTH, 8, bit width of each data channel.
- N_CH, 4, number of input channels; range 2..16.
- SEL_W, 2, width of sel/grant; must satisfy 2**SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- data_in  input  N_CH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- req  input  N_CH  per-channel request; bit k means channel k holds valid data.
- mode  input  1  0 = manual select, 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used in manual mode; ignored in round-robin mode.
- ready_in  input  1  downstream can accept data_out this cycle.
- data_out  output  WIDTH  registered selected data.
- valid_out  output  1  data_out is valid.
- grant  output  SEL_W  registered index of the channel currently in data_out.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - data_out=0, valid_out=0, grant=0.
  - Internal last_grant=N_CH-1, so the first round-robin search starts at channel 0.
- rst takes priority over all other inputs, including mid-stall: a pending unaccepted word is discarded.
- Load condition: load = !valid_out || ready_in. Evaluated every cycle.
- Stall: valid_out=1 and ready_in=0 means data_out, valid_out, grant and last_grant all hold. req, sel and mode are ignored.
- Latency: 1 cycle. A channel selected at edge t appears on data_out after edge t; no combinational path from data_in to data_out.
- Manual mode (mode=0), on load:
  - If sel < N_CH: data_out <= channel[sel]; grant <= sel; valid_out <= req[sel].
  - If sel >= N_CH (out-of-range index): valid_out <= 0; data_out and grant hold.
  - last_grant is not updated in manual mode.
- Round-robin mode (mode=1), on load:
  - Search channels in order last_grant+1, last_grant+2, ... modulo N_CH; pick the first k with req[k]=1.
  - If such a k exists: data_out <= channel[k]; grant <= k; last_grant <= k; valid_out <= 1.
  - If req is all zeros: valid_out <= 0; data_out, grant and last_grant hold.
  - Wrap-around: after channel N_CH-1 is granted, the search restarts at 0.
  - A single persistent requester is granted every load cycle.
- Fairness: with all req=1 and ready_in=1 continuously, grant cycles 0,1,...,N_CH-1,0,... One word per cycle; no channel is granted twice before every other requester has been granted once.
- Mode switch: takes effect at the next load.
  - last_grant is preserved across switches, so round-robin resumes from where it left off.
  - Switching during a stall has no effect until the stall clears.
- Simultaneous events: a load and a new req on the same edge use the req value sampled at that edge. req deasserting for a channel already latched does not retract data_out.
- Throughput: full rate (one transfer per cycle) while ready_in=1.
- No X propagation: all registers reset, and every output is defined in every state.

Test Plan:
- Reset and manual sweep (WIDTH=8, N_CH=4, mode=0, req=4'b1111, ready_in=1):
  - Stimulus: data_in={8'h44,8'h33,8'h22,8'h11}; sel 0,1,2,3 on successive cycles.
  - Response: after rst, data_out=0 and valid_out=0. Then data_out 11,22,33,44 one cycle after each sel, with grant matching sel and valid_out=1.
- Manual with req off and out-of-range (N_CH=3, SEL_W=2):
  - sel=1 with req[1]=0 -> valid_out=0, data_out=channel1.
  - sel=3 -> valid_out=0, and data_out/grant hold their previous values.
- Round-robin fairness (mode=1, req=4'b1111, ready_in=1, 8 cycles):
  - Response: grant sequence 0,1,2,3,0,1,2,3; valid_out=1 throughout.
- Sparse requests and wrap (mode=1):
  - Stimulus: req=4'b1010 for 4 cycles, then req=4'b0001 after grant=3, then req=0.
  - Response: grant 1,3,1,3; then grant 0 with valid_out=1; then valid_out=0 with grant holding at 0.
- Backpressure (mode=1, req=4'b1111):
  - Stimulus: ready_in=0 for 3 cycles after the first grant=0; data_in changes during the stall.
  - Response: data_out, grant=0 and valid_out=1 stable for all 3 cycles. Once ready_in=1, the next grant is 1.
- Reset mid-stall and mode switch:
  - rst=1 during a stall -> next cycle valid_out=0, data_out=0; after release, the round-robin first grant is 0.
  - Round-robin stopped at grant=2, then mode=0 with sel=0 for 2 cycles, then mode=1 with all req -> next round-robin grant=3.

Source files
------------

// File: rtl/rr_mux_reg_if.sv
// rtl/rr_mux_reg_if.sv - channel/handshake bundle for rr_mux_reg
//
// Purpose: groups the packed input channels, request vector, selection
// controls and the registered output handshake of rr_mux_reg.
//
// Signals:
//   data_in   N_CH*WIDTH  packed channels, channel k at [k*WIDTH +: WIDTH]
//   req       N_CH        per-channel request
//   mode      1           0 = manual select, 1 = round-robin
//   sel       SEL_W       manual channel index
//   ready_in  1           downstream accepts data_out this cycle
//   data_out  WIDTH       registered selected data
//   valid_out 1           data_out is valid
//   grant     SEL_W       index of the channel held in data_out
//
// Modports: master drives the inputs and observes the outputs (upstream /
// downstream side); slave is the selector itself.
interface rr_mux_reg_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);
  logic [N_CH*WIDTH-1:0] data_in;
  logic [N_CH-1:0]       req;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  ready_in;
  logic [WIDTH-1:0]      data_out;
  logic                  valid_out;
  logic [SEL_W-1:0]      grant;

  modport master (
    output data_in, req, mode, sel, ready_in,
    input  data_out, valid_out, grant
  );

  modport slave (
    input  data_in, req, mode, sel, ready_in,
    output data_out, valid_out, grant
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel registered selector, manual or round-robin
//
// Purpose: picks one of N_CH WIDTH-bit channels, either by an external index
// (manual mode) or by a fair round-robin arbiter over the requesting channels,
// and registers it onto a valid/ready output. One cycle latency, full rate
// while ready_in is high, everything held while the output is stalled.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_mux_reg_if.slave: data_in/req/mode/sel/ready_in in,
//        data_out/valid_out/grant out (all registered)
module rr_mux_reg #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input logic         clk,
  input logic         rst,
  rr_mux_reg_if.slave bus
);

  logic [WIDTH-1:0] ch [N_CH];

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  logic             load;

  logic             man_ok;
  logic             man_req;
  logic [WIDTH-1:0] man_data;

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] rr_data;
  int               rr_pos;

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch[k] = bus.data_in[k*WIDTH +: WIDTH];
  end

  // A new word may be taken whenever the output register is empty or being drained.
  assign load = !valid_q || bus.ready_in;

  // Manual path: matching sel against every real channel doubles as the
  // range check, so an out-of-range sel simply leaves man_ok low.
  always_comb begin
    man_ok   = 1'b0;
    man_req  = 1'b0;
    man_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(bus.sel) == k) begin
        man_ok   = 1'b1;
        man_req  = bus.req[k];
        man_data = ch[k];
      end
    end
  end

  // Round-robin search: visit candidates from the farthest (last_grant itself)
  // down to the nearest (last_grant+1); the last hit written is therefore the
  // first requester after last_grant in circular order.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_data  = '0;
    rr_pos   = 0;
    for (int i = N_CH; i >= 1; i--) begin
      rr_pos = (int'(last_grant_q) + i) % N_CH;
      if (bus.req[rr_pos]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(rr_pos);
        rr_data  = ch[rr_pos];
      end
    end
  end

  // Next-state: hold by default (covers the stall); on load the active mode
  // decides. last_grant only moves on a round-robin grant so that the arbiter
  // resumes where it stopped after a spell of manual mode.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (!bus.mode) begin
        if (man_ok) begin
          data_d  = man_data;
          grant_d = bus.sel;
          valid_d = man_req;
        end else begin
          valid_d = 1'b0;
        end
      end else begin
        if (rr_found) begin
          data_d       = rr_data;
          grant_d      = rr_idx;
          last_grant_d = rr_idx;
          valid_d      = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
    end
  end

  // Reset parks last_grant on the top channel so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= SEL_W'(N_CH - 1);
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - directed self-checking bench for rr_mux_reg
module tb_rr_mux_reg;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_mux_reg_if #(.WIDTH(8), .N_CH(4), .SEL_W(2)) bus4 ();
  rr_mux_reg_if #(.WIDTH(8), .N_CH(3), .SEL_W(2)) bus3 ();

  rr_mux_reg #(.WIDTH(8), .N_CH(4), .SEL_W(2)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  rr_mux_reg #(.WIDTH(8), .N_CH(3), .SEL_W(2)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] d, input logic v, input logic [1:0] g);
    chk({tag, ".data"},  32'(bus4.data_out),  32'(d));
    chk({tag, ".valid"}, 32'(bus4.valid_out), 32'(v));
    chk({tag, ".grant"}, 32'(bus4.grant),     32'(g));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus4.data_in  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req      = 4'b1111;
    bus4.mode     = 1'b0;
    bus4.sel      = 2'd0;
    bus4.ready_in = 1'b1;
    bus3.data_in  = {8'hc3, 8'hb2, 8'ha1};
    bus3.req      = 3'b101;
    bus3.mode     = 1'b0;
    bus3.sel      = 2'd1;
    bus3.ready_in = 1'b1;

    // reset state
    tick();
    chk4("reset", 8'h00, 1'b0, 2'd0);
    chk("reset3.valid", 32'(bus3.valid_out), 32'd0);
    rst = 1'b0;

    // manual sweep on the 4-channel unit; 3-channel unit runs alongside
    bus4.sel = 2'd0; tick(); chk4("man0", 8'h11, 1'b1, 2'd0);
    chk("n3_reqoff.valid", 32'(bus3.valid_out), 32'd0);
    chk("n3_reqoff.data",  32'(bus3.data_out),  32'hb2);
    chk("n3_reqoff.grant", 32'(bus3.grant),     32'd1);
    bus3.sel = 2'd0;
    bus4.sel = 2'd1; tick(); chk4("man1", 8'h22, 1'b1, 2'd1);
    chk("n3_sel0.valid", 32'(bus3.valid_out), 32'd1);
    chk("n3_sel0.data",  32'(bus3.data_out),  32'ha1);
    bus3.sel = 2'd3;
    bus4.sel = 2'd2; tick(); chk4("man2", 8'h33, 1'b1, 2'd2);
    chk("n3_oor.valid", 32'(bus3.valid_out), 32'd0);
    chk("n3_oor.data",  32'(bus3.data_out),  32'ha1);
    chk("n3_oor.grant", 32'(bus3.grant),     32'd0);
    bus4.sel = 2'd3; tick(); chk4("man3", 8'h44, 1'b1, 2'd3);

    // round-robin fairness: manual mode left last_grant at 3
    bus4.mode = 1'b1;
    tick(); chk4("rr0", 8'h11, 1'b1, 2'd0);
    tick(); chk4("rr1", 8'h22, 1'b1, 2'd1);
    tick(); chk4("rr2", 8'h33, 1'b1, 2'd2);
    tick(); chk4("rr3", 8'h44, 1'b1, 2'd3);
    tick(); chk4("rr4", 8'h11, 1'b1, 2'd0);
    tick(); chk4("rr5", 8'h22, 1'b1, 2'd1);
    tick(); chk4("rr6", 8'h33, 1'b1, 2'd2);
    tick(); chk4("rr7", 8'h44, 1'b1, 2'd3);

    // sparse requests and wrap
    bus4.req = 4'b1010;
    tick(); chk4("sp0", 8'h22, 1'b1, 2'd1);
    tick(); chk4("sp1", 8'h44, 1'b1, 2'd3);
    tick(); chk4("sp2", 8'h22, 1'b1, 2'd1);
    tick(); chk4("sp3", 8'h44, 1'b1, 2'd3);
    bus4.req = 4'b0001;
    tick(); chk4("wrap", 8'h11, 1'b1, 2'd0);
    bus4.req = 4'b0000;
    tick(); chk4("noreq", 8'h11, 1'b0, 2'd0);

    // backpressure from a clean reset
    rst = 1'b1; tick(); rst = 1'b0;
    bus4.req = 4'b1111;
    tick(); chk4("bp_first", 8'h11, 1'b1, 2'd0);
    bus4.ready_in = 1'b0;
    bus4.data_in  = {8'h88, 8'h77, 8'h66, 8'h55};
    tick(); chk4("bp_s0", 8'h11, 1'b1, 2'd0);
    tick(); chk4("bp_s1", 8'h11, 1'b1, 2'd0);
    tick(); chk4("bp_s2", 8'h11, 1'b1, 2'd0);
    bus4.ready_in = 1'b1;
    tick(); chk4("bp_release", 8'h66, 1'b1, 2'd1);

    // reset during a stall discards the pending word
    bus4.ready_in = 1'b0;
    tick(); chk4("st_hold", 8'h66, 1'b1, 2'd1);
    rst = 1'b1;
    tick(); chk4("st_reset", 8'h00, 1'b0, 2'd0);
    rst = 1'b0;
    bus4.ready_in = 1'b1;
    tick(); chk4("post_rst0", 8'h55, 1'b1, 2'd0);
    tick(); chk4("post_rst1", 8'h66, 1'b1, 2'd1);
    tick(); chk4("post_rst2", 8'h77, 1'b1, 2'd2);

    // mode switch: manual spell must not disturb the round-robin pointer
    bus4.mode = 1'b0; bus4.sel = 2'd0;
    tick(); chk4("ms_man0", 8'h55, 1'b1, 2'd0);
    tick(); chk4("ms_man1", 8'h55, 1'b1, 2'd0);
    bus4.mode = 1'b1;
    tick(); chk4("ms_resume", 8'h88, 1'b1, 2'd3);

    // mode switch during a stall waits for the stall to clear
    bus4.ready_in = 1'b0; bus4.mode = 1'b0; bus4.sel = 2'd1;
    tick(); chk4("ms_stall", 8'h88, 1'b1, 2'd3);
    bus4.ready_in = 1'b1;
    tick(); chk4("ms_after", 8'h66, 1'b1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
